sobel_stream: RTL and testbench

Parametrised, pixel-serial successor to the combinational flat-image Sobel filter. It accepts a raster-order grayscale stream of `WIDTH`×`HEIGHT` pixels and keeps two line buffers plus a 3×3 window. It emits one gradient pixel per accepted input pixel through a 2-stage pipeline, either as a binary edge map or as a saturated magnitude. It sits between the frame source and the VGA display buffer.

---
 rtl/sobel_stream.sv | 151 +++++++++++++++
 tb/tb_sobel_stream.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - pixel-serial 3x3 Sobel edge filter with two line buffers
`timescale 1ns/1ps
module sobel_stream #(
    parameter int WIDTH  = 9,
    parameter int HEIGHT = 9,
    parameter int PIX_W  = 8,
    parameter int MODE   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic [PIX_W+2:0] thresh,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_sof,
    output logic             out_eol,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int GW = PIX_W + 3;
    localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

    logic [CW-1:0]    col;
    logic [CW-1:0]    posCol;
    logic [RW-1:0]    row;
    logic [RW-1:0]    posRow;
    logic             lastCol;
    logic             lastRow;
    logic [GW-1:0]    threshQ;
    logic [PIX_W-1:0] lb0 [WIDTH];
    logic [PIX_W-1:0] lb1 [WIDTH];
    logic [PIX_W-1:0] win [3][3];
    logic             s1Valid;
    logic             s1Mask;
    logic             s1Sof;
    logic             s1Eol;
    logic             s1Done;

    // An accepted start-of-frame overrides whatever the counters believe.
    assign posCol  = in_sof ? '0 : col;
    assign posRow  = in_sof ? '0 : row;
    assign lastCol = (posCol == LAST_COL);
    assign lastRow = (posRow == LAST_ROW);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col     <= '0;
            row     <= '0;
            threshQ <= '1;
            s1Valid <= 1'b0;
            s1Mask  <= 1'b0;
            s1Sof   <= 1'b0;
            s1Eol   <= 1'b0;
            s1Done  <= 1'b0;
            for (int y = 0; y < 3; y++) begin
                for (int x = 0; x < 3; x++) begin
                    win[y][x] <= '0;
                end
            end
        end else begin
            s1Valid <= in_valid;
            if (in_valid) begin
                if (in_sof) begin
                    threshQ <= thresh;
                end
                col <= lastCol ? '0 : posCol + 1'b1;
                if (lastCol) begin
                    row <= lastRow ? '0 : posRow + 1'b1;
                end else begin
                    row <= posRow;
                end
                for (int y = 0; y < 3; y++) begin
                    win[y][0] <= win[y][1];
                    win[y][1] <= win[y][2];
                end
                win[0][2] <= lb1[posCol];
                win[1][2] <= lb0[posCol];
                win[2][2] <= in_pixel;
                // The first two rows/cols of a frame see stale or wrapped window data.
                s1Mask <= (posRow < RW'(2)) || (posCol < CW'(2));
                s1Sof  <= (posRow == '0) && (posCol == '0);
                s1Eol  <= lastCol;
                s1Done <= lastCol && lastRow;
            end
        end
    end

    // Line buffers carry no reset; masking hides anything left from before.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb1[posCol] <= lb0[posCol];
            lb0[posCol] <= in_pixel;
        end
    end

    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    logic signed [GW-1:0] gx;
    logic signed [GW-1:0] gy;
    logic [GW-1:0]        absX;
    logic [GW-1:0]        absY;
    logic [GW-1:0]        mag;
    logic [PIX_W-1:0]     result;

    always_comb begin
        gx = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
           - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
        gy = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
           - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
        absX = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        absY = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag  = absX + absY;
    end

    always_comb begin
        result = '0;
        if (!s1Mask) begin
            if (MODE == 0) begin
                result = (mag >= threshQ) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
            end else begin
                result = (|mag[GW-1:PIX_W]) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_pixel  <= '0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= s1Valid;
            out_sof    <= s1Valid && s1Sof;
            out_eol    <= s1Valid && s1Eol;
            frame_done <= s1Valid && s1Done;
            if (s1Valid) begin
                out_pixel <= result;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// tb/tb_sobel_stream.sv - scoreboard bench for sobel_stream in both output modes
`timescale 1ns/1ps
module tb_sobel_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inValid = 1'b0;
    logic        inSof = 1'b0;
    logic [7:0]  inPixel = '0;
    logic [10:0] thresh = 11'd30;

    logic       o0Valid, o0Sof, o0Eol, o0Done;
    logic [7:0] o0Pixel;
    logic       o1Valid, o1Sof, o1Eol, o1Done;
    logic [7:0] o1Pixel;

    sobel_stream #(.WIDTH(9), .HEIGHT(9), .PIX_W(8), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_sof(inSof),
        .in_pixel(inPixel), .thresh(thresh),
        .out_valid(o0Valid), .out_pixel(o0Pixel), .out_sof(o0Sof),
        .out_eol(o0Eol), .frame_done(o0Done)
    );

    sobel_stream #(.WIDTH(9), .HEIGHT(9), .PIX_W(8), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_sof(inSof),
        .in_pixel(inPixel), .thresh(thresh),
        .out_valid(o1Valid), .out_pixel(o1Pixel), .out_sof(o1Sof),
        .out_eol(o1Eol), .frame_done(o1Done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int p0;
        int p1;
        int sof;
        int eol;
        int done;
    } beat_t;

    beat_t sbq[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    beat_t got;
    always @(negedge clk) begin
        if (rst) begin
            if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_beat: actual=no beat by cycle %0d required=beat at cycle %0d",
                         cyc, sbq[0].cyc);
                void'(sbq.pop_front());
            end
            if (o0Valid || o1Valid) begin
                chk("valid_agree", int'(o0Valid), int'(o1Valid));
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: actual=out_valid at cycle %0d required=no beat", cyc);
                end else begin
                    got = sbq.pop_front();
                    chk("latency_cycle", cyc, got.cyc);
                    chk("pixel_mode0", int'(o0Pixel), got.p0);
                    chk("pixel_mode1", int'(o1Pixel), got.p1);
                    chk("out_sof", int'(o1Sof), got.sof);
                    chk("out_eol", int'(o1Eol), got.eol);
                    chk("frame_done", int'(o1Done), got.done);
                    chk("frame_done_mode0", int'(o0Done), got.done);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            inValid = 1'b0;
            inSof   = 1'b0;
        end
    endtask

    // Step frame: cols 0-3 = 0, cols 4-8 = level; Sobel gives 4*level at cols 4,5 once r>=2.
    task automatic sendFrame(input bit isStep, input int level, input int thr,
                             input int gapMax, input int nPix);
        int    k;
        int    mag;
        int    gap;
        beat_t e;
        k = 0;
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 9; c++) begin
                if (k < nPix) begin
                    gap = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
                    repeat (gap) begin
                        @(negedge clk);
                        inValid = 1'b0;
                        inSof   = 1'b0;
                    end
                    @(negedge clk);
                    inValid = 1'b1;
                    inSof   = (r == 0 && c == 0);
                    inPixel = (!isStep || c >= 4) ? 8'(level) : 8'd0;
                    thresh  = 11'(thr);
                    mag     = (isStep && r >= 2 && (c == 4 || c == 5)) ? 4 * level : 0;
                    e.cyc   = cyc + 2;
                    e.p1    = (mag > 255) ? 255 : mag;
                    e.p0    = (r >= 2 && c >= 2 && mag >= thr) ? 255 : 0;
                    e.sof   = (r == 0 && c == 0) ? 1 : 0;
                    e.eol   = (c == 8) ? 1 : 0;
                    e.done  = (r == 8 && c == 8) ? 1 : 0;
                    sbq.push_back(e);
                    k++;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            inValid = ~inValid;
            inSof   = 1'b1;
            inPixel = 8'($urandom);
            #1;
            chk("reset_out_valid", int'(o1Valid || o0Valid), 0);
            chk("reset_out_pixel", int'(o1Pixel | o0Pixel), 0);
            chk("reset_flags", int'(o1Sof | o1Eol | o1Done), 0);
        end
        @(negedge clk);
        inValid = 1'b0;
        inSof   = 1'b0;
        rst     = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after_reset", int'(o1Valid), 0);
        end

        sendFrame(1'b0, 100, 30, 0, 81); idle(3);
        sendFrame(1'b1, 10, 30, 0, 81);  idle(3);
        sendFrame(1'b1, 10, 41, 0, 81);  idle(3);
        sendFrame(1'b1, 255, 30, 0, 81); idle(3);
        sendFrame(1'b1, 10, 30, 2, 81);  idle(3);

        sendFrame(1'b1, 10, 30, 0, 20);
        sendFrame(1'b1, 10, 30, 0, 81);  idle(3);

        sendFrame(1'b1, 10, 30, 0, 42);
        @(posedge clk);
        #2;
        rst     = 1'b0;
        inValid = 1'b0;
        inSof   = 1'b0;
        #1;
        chk("async_reset_valid", int'(o1Valid || o0Valid), 0);
        chk("async_reset_pixel", int'(o1Pixel | o0Pixel), 0);
        sbq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_beat_after_abort", int'(o1Valid || o0Valid), 0);
        end

        sendFrame(1'b1, 10, 30, 0, 81);  idle(5);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
